// File: rtl/batch_seq_pkg.sv
// Shared types and default parameters for the batch sequencer.
// Holds the FSM state encoding and the counter-width helper.
package batch_seq_pkg;

   localparam int unsigned DEF_IDX_W     = 10;
   localparam int unsigned DEF_PULSE_LEN = 3;
   localparam int unsigned DEF_TIMEOUT_W = 16;

   typedef enum logic [1:0] {
      StIdle,
      StPulse,
      StWait,
      StDone
   } seq_state_e;

   // One counter times both PULSE (up to 255) and WAIT, so it must fit either limit.
   function automatic int unsigned cnt_width(input int unsigned timeout_w);
      return (timeout_w > 8) ? timeout_w : 8;
   endfunction

endpackage

// File: rtl/batch_sequencer_if.sv
// Control/status bundle between a batch requester and the batch sequencer.
// The sequencer connects to the slave modport; the requester side uses master.
interface batch_sequencer_if
   import batch_seq_pkg::*;
#(
   parameter int unsigned IDX_W     = DEF_IDX_W,
   parameter int unsigned TIMEOUT_W = DEF_TIMEOUT_W
) ();

   logic                 go;
   logic                 abort;
   logic [IDX_W-1:0]     first_idx;
   logic [IDX_W-1:0]     last_idx;
   logic [TIMEOUT_W-1:0] timeout_lim;
   logic                 job_finish;
   logic [IDX_W-1:0]     job_index;
   logic                 job_start;
   logic                 busy;
   logic                 done;
   logic                 timed_out;
   logic [IDX_W:0]       jobs_done;

   modport master (
      output go, abort, first_idx, last_idx, timeout_lim, job_finish,
      input  job_index, job_start, busy, done, timed_out, jobs_done
   );

   modport slave (
      input  go, abort, first_idx, last_idx, timeout_lim, job_finish,
      output job_index, job_start, busy, done, timed_out, jobs_done
   );

endinterface

// File: rtl/seq_cycle_counter.sv
// Free-running cycle counter with synchronous clear and a compare against a limit.
// hit is high in the cycle whose count, once incremented, equals limit.
module seq_cycle_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] limit,
   output logic         hit
);

   logic [W-1:0] count_q, count_d;
   logic [W:0]   count_inc;

   assign count_inc = {1'b0, count_q} + (W+1)'(1);
   assign hit       = (count_inc == {1'b0, limit});

   always_comb begin
      count_d = count_inc[W-1:0];
      if (load) begin
         count_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/batch_sequencer.sv
// Runs job indices first..last through an external engine: strobe, wait for a
// rising finish edge, advance; supports abort and a per-job WAIT timeout.
module batch_sequencer
   import batch_seq_pkg::*;
#(
   parameter int unsigned IDX_W     = DEF_IDX_W,
   parameter int unsigned PULSE_LEN = DEF_PULSE_LEN,
   parameter int unsigned TIMEOUT_W = DEF_TIMEOUT_W
) (
   input logic              clk,
   input logic              rst,
   batch_sequencer_if.slave bus
);

   localparam int unsigned CNT_W = cnt_width(TIMEOUT_W);

   seq_state_e       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [IDX_W-1:0] last_q, last_d;
   logic [IDX_W:0]   jobs_q, jobs_d;
   logic             to_q, to_d;
   logic             pend_q, pend_d;
   logic             fin_q;
   logic             start_q, busy_q, done_q;
   logic             rise;
   logic             cnt_load, cnt_hit;
   logic [CNT_W-1:0] cnt_limit;

   // fin_q samples every cycle, so a level left high by the previous job never looks like an edge.
   assign rise      = bus.job_finish & ~fin_q;
   assign cnt_limit = (state_q == StPulse) ? CNT_W'(PULSE_LEN) : CNT_W'(bus.timeout_lim);
   assign cnt_load  = (state_d != state_q);

   seq_cycle_counter #(
      .W(CNT_W)
   ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (cnt_load),
      .limit(cnt_limit),
      .hit  (cnt_hit)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      jobs_d  = jobs_q;
      to_d    = to_q;
      pend_d  = pend_q;
      unique case (state_q)
         StIdle: begin
            if (bus.go) begin
               jobs_d = '0;
               to_d   = 1'b0;
               if (bus.first_idx <= bus.last_idx) begin
                  idx_d   = bus.first_idx;
                  last_d  = bus.last_idx;
                  pend_d  = 1'b0;
                  state_d = StPulse;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StPulse: begin
            if (rise) begin
               pend_d = 1'b1;
            end
            if (bus.abort) begin
               state_d = StDone;
            end else if (cnt_hit) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (bus.abort) begin
               state_d = StDone;
            end else if (pend_q || rise) begin
               jobs_d = jobs_q + (IDX_W+1)'(1);
               pend_d = 1'b0;
               // Compare before incrementing so last_idx at the top of the range cannot wrap.
               if (idx_q == last_q) begin
                  state_d = StDone;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = StPulse;
               end
            end else if ((bus.timeout_lim != '0) && cnt_hit) begin
               to_d    = 1'b1;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         last_q  <= '0;
         jobs_q  <= '0;
         to_q    <= 1'b0;
         pend_q  <= 1'b0;
         fin_q   <= 1'b0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         jobs_q  <= jobs_d;
         to_q    <= to_d;
         pend_q  <= pend_d;
         fin_q   <= bus.job_finish;
         start_q <= (state_d == StPulse);
         busy_q  <= (state_d != StIdle);
         done_q  <= (state_d == StDone);
      end
   end

   assign bus.job_index = idx_q;
   assign bus.job_start = start_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.timed_out = to_q;
   assign bus.jobs_done = jobs_q;

endmodule

// File: tb/tb_batch_sequencer.sv
// Bench for batch_sequencer: a vector table of whole batches with a job-engine
// model, a start-index scoreboard, plus hand-written reset corner cases.
module tb_batch_sequencer;

   localparam int unsigned IDX_W     = 10;
   localparam int unsigned PULSE_LEN = 3;
   localparam int unsigned TIMEOUT_W = 16;
   localparam int          NVEC      = 10;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   batch_sequencer_if #(
      .IDX_W    (IDX_W),
      .TIMEOUT_W(TIMEOUT_W)
   ) bus ();

   batch_sequencer #(
      .IDX_W    (IDX_W),
      .PULSE_LEN(PULSE_LEN),
      .TIMEOUT_W(TIMEOUT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // delay: cycles from first WAIT cycle to finish rising (-1 = never);
   // early: raise finish in the 2nd PULSE cycle; abort_job: abort with that job's finish.
   typedef struct {
      int first;
      int last;
      int tmo;
      int delay;
      int abort_job;
      bit early;
      bit hold_go;
      int exp_jobs;
      bit exp_to;
   } vec_t;

   vec_t vecs[NVEC];
   int   n_chk  = 0;
   int   n_pass = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic run_vec(input vec_t v, input int id);
      int exp_q[$];
      int n_starts, cyc, fall_cyc, hi, wcnt, starts;
      bit tmo_exp, done_seen, prev_js;
      tmo_exp = (v.tmo != 0) && !v.early && (v.delay < 0 || v.delay >= v.tmo);
      if (v.first > v.last) n_starts = 0;
      else if (v.abort_job > 0) n_starts = v.abort_job;
      else if (tmo_exp) n_starts = 1;
      else n_starts = v.last - v.first + 1;
      for (int i = 0; i < n_starts; i++) exp_q.push_back(v.first + i);

      @(negedge clk);
      bus.first_idx   = IDX_W'(v.first);
      bus.last_idx    = IDX_W'(v.last);
      bus.timeout_lim = TIMEOUT_W'(v.tmo);
      bus.go          = 1'b1;
      bus.abort       = 1'b0;
      cyc = 0; fall_cyc = 0; hi = 0; wcnt = -1; starts = 0;
      done_seen = 1'b0; prev_js = 1'b0;
      while (!done_seen && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         if (!v.hold_go) bus.go = 1'b0;
         bus.abort = 1'b0;
         if (bus.job_start && !prev_js) begin
            starts++;
            hi = 0;
            bus.job_finish = 1'b0;
            if (exp_q.size() > 0)
               check($sformatf("v%0d start_index", id), bus.job_index, exp_q.pop_front());
         end
         if (bus.job_start) begin
            hi++;
            if (v.early && hi == 2) bus.job_finish = 1'b1;
         end
         if (wcnt > 0) wcnt--;
         if (!bus.job_start && prev_js) begin
            check($sformatf("v%0d pulse_len", id), hi, PULSE_LEN);
            fall_cyc = cyc;
            if (!v.early && v.delay >= 0) wcnt = v.delay;
         end
         if (wcnt == 0) begin
            bus.job_finish = 1'b1;
            if (starts == v.abort_job) bus.abort = 1'b1;
            wcnt = -1;
         end
         if (bus.done) begin
            done_seen = 1'b1;
            check($sformatf("v%0d jobs_done", id), bus.jobs_done, v.exp_jobs);
            check($sformatf("v%0d timed_out", id), bus.timed_out, v.exp_to);
            if (n_starts > 0)
               check($sformatf("v%0d final_index", id), bus.job_index, v.first + n_starts - 1);
            if (tmo_exp)
               check($sformatf("v%0d wait_cycles", id), cyc - fall_cyc, v.tmo);
            if (v.first > v.last)
               check($sformatf("v%0d empty_latency_le2", id), cyc <= 2, 1);
         end
         prev_js = bus.job_start;
      end
      bus.go = 1'b0;
      check($sformatf("v%0d done_seen", id), done_seen, 1);
      check($sformatf("v%0d start_count", id), starts, n_starts);
      @(negedge clk);
      check($sformatf("v%0d done_one_cycle", id), bus.done, 0);
      check($sformatf("v%0d busy_after", id), bus.busy, 0);
      repeat (3) @(negedge clk);
      check($sformatf("v%0d jobs_done_hold", id), bus.jobs_done, v.exp_jobs);
      check($sformatf("v%0d timed_out_hold", id), bus.timed_out, v.exp_to);
      if (n_starts > 0)
         check($sformatf("v%0d index_hold", id), bus.job_index, v.first + n_starts - 1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " job_index"}, bus.job_index, 0);
      check({tag, " job_start"}, bus.job_start, 0);
      check({tag, " busy"}, bus.busy, 0);
      check({tag, " done"}, bus.done, 0);
      check({tag, " timed_out"}, bus.timed_out, 0);
      check({tag, " jobs_done"}, bus.jobs_done, 0);
   endtask

   initial begin
      //          first last tmo delay abort early hold  jobs to
      vecs[0] = '{1,    2,   0,  20,   0,    0,    0,    2,   0};
      vecs[1] = '{5,    4,   0,  20,   0,    0,    0,    0,   0};
      vecs[2] = '{0,    0,   50, -1,   0,    0,    0,    0,   1};
      vecs[3] = '{1023, 1023,0,  3,    0,    0,    0,    1,   0};
      vecs[4] = '{1,    3,   0,  5,    2,    0,    0,    1,   0};
      vecs[5] = '{7,    10,  0,  0,    0,    0,    1,    4,   0};
      vecs[6] = '{2,    4,   0,  0,    0,    1,    0,    3,   0};
      vecs[7] = '{3,    3,   10, 4,    0,    0,    0,    1,   0};
      vecs[8] = '{0,    5,   8,  30,   0,    0,    0,    0,   1};
      vecs[9] = '{6,    6,   0,  1,    0,    0,    0,    1,   0};

      bus.go = 1'b0; bus.abort = 1'b0; bus.job_finish = 1'b0;
      bus.first_idx = '0; bus.last_idx = '0; bus.timeout_lim = '0;
      #2;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NVEC; i++) run_vec(vecs[i], i);

      // Reset in the 2nd PULSE cycle must clear outputs without a clock edge.
      @(negedge clk);
      bus.first_idx = IDX_W'(1); bus.last_idx = IDX_W'(2); bus.timeout_lim = '0;
      bus.go = 1'b1;
      @(negedge clk);
      bus.go = 1'b0;
      check("midpulse start_before_rst", bus.job_start, 1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_all_zero("async_reset");
      @(negedge clk);
      rst = 1'b0;
      bus.job_finish = 1'b0;

      // Finish rising in IDLE after reset release must not start or count anything.
      @(negedge clk);
      bus.job_finish = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_finish busy", bus.busy, 0);
      check("idle_finish jobs_done", bus.jobs_done, 0);
      run_vec(vecs[0], 100);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/batch_sequencer.md
BATCH_SEQUENCER -- requirements
Module: batch_sequencer

Interface
REQ-001 Parameter IDX_W, default 10, width of the job index.
REQ-002 Parameter PULSE_LEN, default 3, number of clk cycles job_start is held high per job (legal range 1..255).
REQ-003 Parameter TIMEOUT_W, default 16, width of the per-job timeout limit.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 go  input  1  request to run a batch; sampled only in IDLE.
REQ-007 abort  input  1  terminate the running batch.
REQ-008 first_idx  input  IDX_W  first job index, inclusive.
REQ-009 last_idx  input  IDX_W  last job index, inclusive.
REQ-010 timeout_lim  input  TIMEOUT_W  maximum WAIT cycles per job; 0 disables the timeout.
REQ-011 job_finish  input  1  completion level from the job engine.
REQ-012 job_index  output  IDX_W  index of the current job.
REQ-013 job_start  output  1  start strobe to the job engine.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 done  output  1  one-cycle end-of-batch pulse.
REQ-016 timed_out  output  1  sticky timeout flag; cleared on the next accepted go.
REQ-017 jobs_done  output  IDX_W+1  count of jobs completed in the current or last batch.

Function
REQ-018 All outputs SHALL be registered.
REQ-019 The FSM SHALL have exactly the states IDLE, PULSE, WAIT and DONE.
REQ-020 IDLE with go=1 and first_idx<=last_idx SHALL latch both bounds, load job_index=first_idx, clear jobs_done and timed_out, and enter PULSE.
REQ-021 IDLE with go=1 and first_idx>last_idx SHALL issue no job_start, set jobs_done=0, and enter DONE.
REQ-022 PULSE SHALL hold job_start=1 for exactly PULSE_LEN cycles, then enter WAIT with job_start=0.
REQ-023 Completion SHALL be a rising edge of job_finish, detected from the first PULSE cycle onward; a level still high from the previous job SHALL NOT count.
REQ-024 A rising edge of job_finish seen during PULSE SHALL be held and acted on at the first WAIT cycle.
REQ-025 On completion in WAIT, jobs_done SHALL increment; if job_index==latched last the FSM SHALL enter DONE, otherwise job_index SHALL increment and the FSM SHALL enter PULSE.
REQ-026 job_index SHALL never wrap: last_idx = 2^IDX_W-1 SHALL terminate, because the index is compared before it is incremented.
REQ-027 The WAIT cycle counter SHALL reset to 0 on each entry to WAIT.
REQ-028 With timeout_lim!=0, the WAIT count reaching timeout_lim SHALL set timed_out=1 and enter DONE without incrementing jobs_done.
REQ-029 abort=1 in PULSE or WAIT SHALL enter DONE on the next edge, with job_start low from that edge onward.
REQ-030 abort SHALL win over a completion or timeout in the same cycle; no increment SHALL occur.
REQ-031 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-032 go SHALL be ignored while busy=1.
REQ-033 jobs_done, job_index and timed_out SHALL hold their values in IDLE until the next accepted go.

Reset
REQ-034 rst=1 SHALL asynchronously force IDLE and set every output to 0, including mid-PULSE and mid-WAIT.
REQ-035 The internal counters, latched bounds and the finish edge register SHALL reset to 0.
REQ-036 After reset release, the first rising edge of job_finish SHALL NOT be mistaken for a completion while in IDLE.

Structure
REQ-037 Package batch_seq_pkg SHALL hold the FSM state enumeration and the default parameter constants.
REQ-038 One sub-module, seq_cycle_counter, SHALL provide the load/count/compare counter used for the PULSE length and the WAIT timeout.

Verification
REQ-039 first=1, last=2, finish rising 20 cycles after each start falls -> two 3-cycle job_start pulses at index 1 then 2, one done pulse, jobs_done=2, timed_out=0.
REQ-040 first=5, last=4, go -> done within 2 cycles, no job_start, jobs_done=0.
REQ-041 timeout_lim=50, finish held low -> timed_out=1 after 50 WAIT cycles, done pulse, busy=0, jobs_done=0.
REQ-042 IDX_W=10, first=last=1023 -> exactly one job, job_index stays 1023, jobs_done=1.
REQ-043 abort in the same cycle as finish rises for job 2 of range 1..3 -> jobs_done=1, no third start pulse.
REQ-044 rst asserted in the 2nd PULSE cycle -> all outputs 0 immediately, without waiting for a clk edge; a fresh go then runs normally.
